// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the instruction-fetch slice of the CPU:
//   OP_HALT          opcode that stops the fetch engine
//   CP_SEQ/CP_JR/    next-PC kind selected by the controller
//   CP_J/CP_BR
//   fetch_state_t    states of the fetch state machine
// ---------------------------------------------------------------------------
package cpu_pkg;

  localparam logic [5:0] OP_HALT = 6'b111111;

  localparam logic [1:0] CP_SEQ = 2'b00;
  localparam logic [1:0] CP_JR  = 2'b01;
  localparam logic [1:0] CP_J   = 2'b10;
  localparam logic [1:0] CP_BR  = 2'b11;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/next_pc_unit.sv
// ---------------------------------------------------------------------------
// next_pc_unit
// Combinational next-PC selection and arithmetic. All results are taken
// modulo 2^ADDR_W, so the PC wraps silently.
// Ports:
//   pc        current instruction word address
//   inst      current latched instruction (jump target / branch offset)
//   cp_type   next-PC kind (CP_SEQ, CP_JR, CP_J, CP_BR)
//   enbranch  branch taken flag for CP_BR
//   rs_val    jump-register target (word address)
//   next_pc   selected next PC
// ---------------------------------------------------------------------------
module next_pc_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 14
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [31:0]       inst,
  input  logic [1:0]        cp_type,
  input  logic              enbranch,
  input  logic [31:0]       rs_val,
  output logic [ADDR_W-1:0] next_pc
);

  logic [ADDR_W-1:0] pc_inc;
  logic [31:0]       br_off;
  logic              unused_bits;

  assign pc_inc = pc + ADDR_W'(1);

  // Branch offset is a signed 16-bit word displacement relative to pc+1;
  // extending to 32 bits first keeps the slice valid for any ADDR_W <= 32.
  assign br_off = {{16{inst[15]}}, inst[15:0]};

  assign unused_bits = ^{inst, rs_val};

  always_comb begin
    next_pc = pc_inc;
    case (cp_type)
      CP_SEQ: next_pc = pc_inc;
      CP_JR:  next_pc = rs_val[ADDR_W-1:0];
      CP_J:   next_pc = inst[ADDR_W-1:0];
      CP_BR:  next_pc = enbranch ? (pc_inc + br_off[ADDR_W-1:0]) : pc_inc;
      default: next_pc = pc_inc;
    endcase
  end

endmodule

// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------
// inst_fetch
// Instruction fetch engine: requests the word at pc, latches the returned
// instruction, waits for the controller to commit the next PC, and stops
// permanently (until reset) when the halt opcode is fetched.
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   write_pc             commit next PC (only honoured in HOLD)
//   cp_type, enbranch    next-PC kind and branch-taken flag
//   rs_val               jump-register target
//   imem_req/addr        instruction memory read request and word address
//   imem_ack/rdata       memory response (accepted only in FETCH)
//   inst, opecode, funct latched instruction and its fields
//   inst_valid           inst holds a freshly fetched instruction
//   halt                 halt opcode has been fetched
//   pc                   address of the current instruction
//   fetch_count          accepted fetches (only with INST_COUNT_EN)
// Build option: define INST_COUNT_EN to add the fetch_count output.
// ---------------------------------------------------------------------------
module inst_fetch
  import cpu_pkg::*;
#(
  parameter int          ADDR_W   = 14,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              write_pc,
  input  logic [1:0]        cp_type,
  input  logic              enbranch,
  input  logic [31:0]       rs_val,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       inst,
  output logic [5:0]        opecode,
  output logic [5:0]        funct,
  output logic              inst_valid,
  output logic              halt,
  output logic [ADDR_W-1:0] pc
`ifdef INST_COUNT_EN
  ,
  output logic [31:0]       fetch_count
`endif
);

  fetch_state_t      state;
  fetch_state_t      state_next;
  logic              started;
  logic              accept;
  logic              commit;
  logic              is_halt;
  logic [ADDR_W-1:0] next_pc;

  next_pc_unit #(.ADDR_W(ADDR_W)) u_next_pc (
    .pc       (pc),
    .inst     (inst),
    .cp_type  (cp_type),
    .enbranch (enbranch),
    .rs_val   (rs_val),
    .next_pc  (next_pc)
  );

  // The state register resets to FETCH, but the request is qualified by
  // 'started' so that imem_req stays low while reset is asserted and only
  // rises after the first clock edge with rstn high. Acks seen before that
  // are dropped, which also discards replies to a fetch abandoned by reset.
  assign imem_req  = (state == FETCH) && started;
  assign imem_addr = pc;
  assign accept    = imem_req && imem_ack;
  assign commit    = (state == HOLD) && write_pc;
  assign is_halt   = (imem_rdata[31:26] == OP_HALT);

  assign opecode = inst[31:26];
  assign funct   = inst[5:0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= FETCH;
      started <= 1'b0;
    end else begin
      state   <= state_next;
      started <= 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      FETCH: begin
        if (accept) begin
          state_next = is_halt ? HALT : HOLD;
        end
      end
      HOLD: begin
        if (write_pc) begin
          state_next = FETCH;
        end
      end
      HALT: begin
        state_next = HALT;
      end
      default: state_next = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc         <= ADDR_W'(RESET_PC);
      inst       <= 32'd0;
      inst_valid <= 1'b0;
      halt       <= 1'b0;
    end else begin
      if (accept) begin
        inst       <= imem_rdata;
        inst_valid <= 1'b1;
        halt       <= is_halt;
      end else if (commit) begin
        pc         <= next_pc;
        inst_valid <= 1'b0;
      end
    end
  end

`ifdef INST_COUNT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fetch_count <= 32'd0;
    end else if (accept) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch
// Randomized, scoreboard-based bench for inst_fetch. The stimulus process
// plays the memory and controller, pushes the expected latched instruction
// into a queue on each ack, and tracks the PC with plain integer arithmetic.
// A separate monitor pops and compares whenever inst_valid rises.
// ---------------------------------------------------------------------------
module tb_inst_fetch;

  localparam int ADDR_W = 14;
  localparam int PC_MOD = 1 << ADDR_W;

  typedef struct packed {
    logic [31:0] inst;
    logic [13:0] pc;
    logic        halt;
  } exp_t;

  logic        clk;
  logic        rstn;
  logic        write_pc;
  logic [1:0]  cp_type;
  logic        enbranch;
  logic [31:0] rs_val;
  logic        imem_req;
  logic [13:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic [5:0]  opecode;
  logic [5:0]  funct;
  logic        inst_valid;
  logic        halt;
  logic [13:0] pc;
`ifdef INST_COUNT_EN
  logic [31:0] fetch_count;
`endif

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  int   model_pc = 0;
  int   model_count = 0;
  logic [31:0] model_inst = 32'd0;

  inst_fetch #(.ADDR_W(ADDR_W), .RESET_PC(0)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .write_pc   (write_pc),
    .cp_type    (cp_type),
    .enbranch   (enbranch),
    .rs_val     (rs_val),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .inst       (inst),
    .opecode    (opecode),
    .funct      (funct),
    .inst_valid (inst_valid),
    .halt       (halt),
    .pc         (pc)
`ifdef INST_COUNT_EN
    ,
    .fetch_count (fetch_count)
`endif
  );

  // Free-running clock, 10 time units per period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point shared by the stimulus and monitor processes
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: whenever a fresh instruction appears, pop the expected entry
  initial begin
    logic prev_valid;
    exp_t e;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (inst_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_inst: got %h expected none", inst);
        end else begin
          e = exp_q.pop_front();
          checkOutput("mon_inst", inst, e.inst);
          checkOutput("mon_pc", 32'(pc), 32'(e.pc));
          checkOutput("mon_opecode", 32'(opecode), 32'(e.inst[31:26]));
          checkOutput("mon_funct", 32'(funct), 32'(e.inst[5:0]));
          checkOutput("mon_halt", 32'(halt), 32'(e.halt));
        end
      end
      prev_valid = inst_valid;
    end
  end

  // Assert reset, check the asynchronous reset values, release mid-cycle
  task automatic resetDut();
    @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("rst_req", 32'(imem_req), 32'd0);
    checkOutput("rst_pc", 32'(pc), 32'd0);
    checkOutput("rst_inst", inst, 32'd0);
    checkOutput("rst_valid", 32'(inst_valid), 32'd0);
    checkOutput("rst_halt", 32'(halt), 32'd0);
    model_pc = 0;
    model_count = 0;
    model_inst = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  // Wait (bounded) until the DUT requests, then check the address
  task automatic waitReq(output bit ok);
    int n;
    n = 0;
    while (!imem_req && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    ok = imem_req;
    if (!ok) begin
      checks++;
      errors++;
      $display("[TB] FAIL req_timeout: got imem_req=0 expected 1");
    end else begin
      checkOutput("req_addr", 32'(imem_addr), 32'(model_pc));
    end
  endtask

  // Serve one fetch with 'lat' wait cycles; optionally poke write_pc while
  // the fetch is outstanding, which must not move the PC
  task automatic fetchInst(input logic [31:0] data, input int lat, input bit stray);
    bit ok;
    exp_t e;
    waitReq(ok);
    if (ok) begin
      for (int i = 0; i < lat; i++) begin
        if (stray && i == 0) begin
          write_pc = 1'b1;
          cp_type  = 2'(($urandom_range(0, 3)));
          rs_val   = $urandom;
        end
        @(posedge clk);
        #1;
        write_pc = 1'b0;
        if (stray && i == 0) checkOutput("stray_pc", 32'(pc), 32'(model_pc));
      end
      imem_ack   = 1'b1;
      imem_rdata = data;
      e.inst = data;
      e.pc   = 14'(model_pc);
      e.halt = (data[31:26] == 6'h3F);
      exp_q.push_back(e);
      model_inst = data;
      model_count++;
      @(posedge clk);
      #1;
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
`ifdef INST_COUNT_EN
      checkOutput("fetch_count", fetch_count, 32'(model_count));
`endif
    end
  endtask

  // Controller commit: PC rule evaluated with integer arithmetic
  task automatic applyStimulus(input logic [1:0] cp, input logic en, input logic [31:0] rs);
    int off;
    int t;
    write_pc = 1'b1;
    cp_type  = cp;
    enbranch = en;
    rs_val   = rs;
    off = int'(model_inst[15:0]);
    if (off >= 32768) off = off - 65536;
    case (cp)
      2'b00: t = model_pc + 1;
      2'b01: t = int'(rs % 32'(PC_MOD));
      2'b10: t = int'(model_inst % 32'(PC_MOD));
      default: t = en ? (model_pc + 1 + off) : (model_pc + 1);
    endcase
    model_pc = ((t % PC_MOD) + PC_MOD) % PC_MOD;
    @(posedge clk);
    #1;
    write_pc = 1'b0;
    checkOutput("commit_pc", 32'(pc), 32'(model_pc));
    checkOutput("commit_req", 32'(imem_req), 32'd1);
  endtask

  function automatic logic [31:0] randInst();
    logic [31:0] r;
    r = $urandom;
    if (r[31:26] == 6'h3F) r[31:26] = 6'h00;
    return r;
  endfunction

  initial begin
    bit ok;
    logic [31:0] r;
    rstn       = 1'b1;
    write_pc   = 1'b0;
    cp_type    = 2'b00;
    enbranch   = 1'b0;
    rs_val     = 32'd0;
    imem_ack   = 1'b0;
    imem_rdata = 32'd0;

    resetDut();
    @(posedge clk);
    #1;

    // First fetch acked in the request cycle
    fetchInst(32'h0000_0020, 0, 1'b0);

    // Branch taken and not taken from pc=5
    applyStimulus(2'b01, 1'b0, 32'd5);
    fetchInst(32'h1000_FFFD, 1, 1'b0);
    applyStimulus(2'b11, 1'b1, 32'd0);
    fetchInst(randInst(), 0, 1'b0);
    applyStimulus(2'b01, 1'b0, 32'd5);
    fetchInst(32'h1000_FFFD, 2, 1'b1);
    applyStimulus(2'b11, 1'b0, 32'd0);

    // Wrap at the top of the address space
    fetchInst(randInst(), 0, 1'b0);
    applyStimulus(2'b01, 1'b0, 32'd16383);
    fetchInst(randInst(), 1, 1'b0);
    applyStimulus(2'b00, 1'b0, 32'd0);
    fetchInst(randInst(), 0, 1'b0);
    applyStimulus(2'b01, 1'b0, 32'd16383);
    fetchInst(randInst(), 0, 1'b0);
    applyStimulus(2'b01, 1'b0, 32'h0001_2345);

    // Randomized sequence of fetches and commits
    for (int k = 0; k < 40; k++) begin
      fetchInst(randInst(), int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
      applyStimulus(2'(($urandom_range(0, 3))), 1'($urandom_range(0, 1)), $urandom);
    end

    // Halt: no further requests, commits and acks ignored
    fetchInst(32'hFC00_0000, 1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      write_pc   = 1'b1;
      cp_type    = 2'b01;
      rs_val     = 32'd77;
      imem_ack   = 1'b1;
      imem_rdata = 32'h1234_5678;
      @(posedge clk);
      #1;
      write_pc = 1'b0;
      imem_ack = 1'b0;
      checkOutput("halt_req", 32'(imem_req), 32'd0);
      checkOutput("halt_pc", 32'(pc), 32'(model_pc));
      checkOutput("halt_flag", 32'(halt), 32'd1);
      checkOutput("halt_inst", inst, 32'hFC00_0000);
    end

    // Reset in the middle of a slow fetch; the late ack must be dropped
    resetDut();
    waitReq(ok);
    repeat (2) @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("midrst_req", 32'(imem_req), 32'd0);
    checkOutput("midrst_pc", 32'(pc), 32'd0);
    @(posedge clk);
    #1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    imem_ack = 1'b0;
    rstn     = 1'b1;
    checkOutput("midrst_inst", inst, 32'd0);
    checkOutput("midrst_valid", 32'(inst_valid), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("midrst_req_after", 32'(imem_req), 32'd1);
    checkOutput("midrst_pc_after", 32'(pc), 32'd0);

    // Recovery plus a run of sequential fetches
    for (int k = 0; k < 10; k++) begin
      r = randInst();
      fetchInst(r, int'($urandom_range(0, 2)), 1'b1);
      applyStimulus(2'b00, 1'b0, 32'd0);
    end

    repeat (3) @(posedge clk);
    checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
